// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types, rounding-mode encodings, flag indices and helpers
package fpu_pkg;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // fflags = {NV, DZ, OF, UF, NX}
   localparam int FF_NV = 4;
   localparam int FF_DZ = 3;
   localparam int FF_OF = 2;
   localparam int FF_UF = 1;
   localparam int FF_NX = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLASS,
      ST_MUL,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic zero;
      logic inf;
      logic qnan;
      logic snan;
   } fp_class_t;

   // Positive quiet NaN with only the fraction MSB set; callers size-cast to their width.
   function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
      logic [63:0] v;
      v = ((64'd1 << exp_w) - 64'd1) << man_w;
      v = v | (64'd1 << (man_w - 1));
      return v;
   endfunction

   // Operand is passed zero-extended to 64 bits. exp==0 counts as zero (subnormals flushed).
   function automatic fp_class_t classify(input logic [63:0] x, input int exp_w, input int man_w);
      logic [63:0] exp_ones;
      logic [63:0] exp_f;
      logic [63:0] man_f;
      logic        man_msb;
      fp_class_t   c;
      exp_ones = (64'd1 << exp_w) - 64'd1;
      exp_f    = (x >> man_w) & exp_ones;
      man_f    = x & ((64'd1 << man_w) - 64'd1);
      man_msb  = ((man_f >> (man_w - 1)) & 64'd1) != 64'd0;
      c.zero   = (exp_f == 64'd0);
      c.inf    = (exp_f == exp_ones) && (man_f == 64'd0);
      c.qnan   = (exp_f == exp_ones) && man_msb;
      c.snan   = (exp_f == exp_ones) && (man_f != 64'd0) && !man_msb;
      return c;
   endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// rtl/fpu_round_pack.sv - combinational rounding, overflow/underflow selection and packing
module fpu_round_pack
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   sign,
   input  logic [EXP_W+1:0]       exp_in,
   input  logic [MAN_W:0]         sig,
   input  logic                   guard,
   input  logic                   rnd,
   input  logic                   sticky,
   input  logic [2:0]             rm,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [4:0]             fflags
);

   localparam logic [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
   localparam logic [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

   logic             inexact;
   logic             inc;
   logic             to_inf;
   logic [MAN_W+1:0] sig_inc;
   logic [MAN_W-1:0] frac_r;
   logic [EXP_W+1:0] exp_r;
   logic             ovf;
   logic             unf;

   // Round-increment decision, carry renormalisation, then overflow/underflow/normal packing.
   always_comb begin
      result  = '0;
      fflags  = '0;
      inexact = guard | rnd | sticky;
      case (rm)
         RM_RTZ: begin inc = 1'b0;            to_inf = 1'b0;  end
         RM_RDN: begin inc = sign & inexact;  to_inf = sign;  end
         RM_RUP: begin inc = ~sign & inexact; to_inf = ~sign; end
         RM_RMM: begin inc = guard;           to_inf = 1'b1;  end
         default: begin inc = guard & (rnd | sticky | sig[0]); to_inf = 1'b1; end
      endcase
      sig_inc = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
      // A carry out leaves 10..0, so dropping the LSB loses nothing.
      if (sig_inc[MAN_W+1]) begin
         frac_r = sig_inc[MAN_W:1];
         exp_r  = exp_in + EXP_ONE;
      end else begin
         frac_r = sig_inc[MAN_W-1:0];
         exp_r  = exp_in;
      end
      ovf = $signed(exp_r) >= $signed(EXP_MAX);
      unf = exp_r[EXP_W+1] | (exp_r == '0);
      if (ovf) begin
         fflags[FF_OF] = 1'b1;
         fflags[FF_NX] = 1'b1;
         result = to_inf ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                         : {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end else if (unf) begin
         fflags[FF_UF] = 1'b1;
         fflags[FF_NX] = 1'b1;
         result = {sign, {(EXP_W+MAN_W){1'b0}}};
      end else begin
         fflags[FF_NX] = inexact;
         result = {sign, exp_r[EXP_W-1:0], frac_r};
      end
   end

endmodule

// File: rtl/fpu_mul_iter.sv
// rtl/fpu_mul_iter.sv - iterative shift-add IEEE-754 multiplier with valid/ready handshake
module fpu_mul_iter
   import fpu_pkg::*;
#(
   parameter int EXP_W    = 8,
   parameter int MAN_W    = 23,
   parameter int MUL_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic [2:0]           rm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic [4:0]           fflags,
   output logic                 busy
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int SIG_W = MAN_W + 1;
   localparam int P_W   = 2 * SIG_W;
   localparam int K     = SIG_W / MUL_BITS;
   localparam int CNT_W = $clog2(K + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [EXP_W+1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
   localparam logic [EXP_W+1:0] EXP_ONE  = {{(EXP_W+1){1'b0}}, 1'b1};
   localparam logic [W-1:0]     QNAN     = W'(canonical_nan(EXP_W, MAN_W));

   generate
      if ((SIG_W % MUL_BITS) != 0) begin : g_bad_mul_bits
         $error("fpu_mul_iter: SIG_W must be a multiple of MUL_BITS");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [2:0]       rm_q, rm_d;
   logic             spec_q, spec_d;
   logic [P_W-1:0]   mcand_q, mcand_d, prod_q, prod_d;
   logic [SIG_W-1:0] mplier_q, mplier_d, sig_q, sig_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [EXP_W+1:0] exp_q, exp_d;
   logic             sign_q, sign_d;
   logic [2:0]       grs_q, grs_d;
   logic [W-1:0]     result_q, result_d;
   logic [4:0]       fflags_q, fflags_d;
   logic             out_valid_q, out_valid_d;

   fp_class_t        cls_a, cls_b;
   logic             sign_ab, special;
   logic [W-1:0]     spec_res;
   logic [4:0]       spec_flags;
   logic [P_W-1:0]   partial;
   logic [W-1:0]     rp_result;
   logic [4:0]       rp_flags;

   assign cls_a   = classify({{(64-W){1'b0}}, a_q}, EXP_W, MAN_W);
   assign cls_b   = classify({{(64-W){1'b0}}, b_q}, EXP_W, MAN_W);
   assign sign_ab = a_q[W-1] ^ b_q[W-1];
   assign partial = mcand_q * {{(P_W-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};

   fpu_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
      .sign   (sign_q),
      .exp_in (exp_q),
      .sig    (sig_q),
      .guard  (grs_q[2]),
      .rnd    (grs_q[1]),
      .sticky (grs_q[0]),
      .rm     (rm_q),
      .result (rp_result),
      .fflags (rp_flags)
   );

   // Special-operand result selection in priority order: NaN, Inf*0, Inf, zero.
   always_comb begin
      spec_res   = '0;
      spec_flags = '0;
      special    = 1'b1;
      if (cls_a.qnan | cls_a.snan | cls_b.qnan | cls_b.snan) begin
         spec_res          = QNAN;
         spec_flags[FF_NV] = cls_a.snan | cls_b.snan;
      end else if ((cls_a.inf & cls_b.zero) | (cls_a.zero & cls_b.inf)) begin
         spec_res          = QNAN;
         spec_flags[FF_NV] = 1'b1;
      end else if (cls_a.inf | cls_b.inf) begin
         spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (cls_a.zero | cls_b.zero) begin
         spec_res = {sign_ab, {(EXP_W+MAN_W){1'b0}}};
      end else begin
         special = 1'b0;
      end
   end

   // FSM next state plus datapath updates for each phase of the operation.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      rm_d        = rm_q;
      spec_d      = spec_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      prod_d      = prod_q;
      cnt_d       = cnt_q;
      exp_d       = exp_q;
      sign_d      = sign_q;
      sig_d       = sig_q;
      grs_d       = grs_q;
      result_d    = result_q;
      fflags_d    = fflags_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               rm_d    = rm;
               spec_d  = 1'b0;
               state_d = ST_CLASS;
            end
         end
         ST_CLASS: begin
            sign_d = sign_ab;
            // Specials spend a second CLASS cycle with the result already registered.
            if (spec_q) begin
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else if (special) begin
               result_d = spec_res;
               fflags_d = spec_flags;
               spec_d   = 1'b1;
            end else begin
               mcand_d  = {{SIG_W{1'b0}}, 1'b1, a_q[MAN_W-1:0]};
               mplier_d = {1'b1, b_q[MAN_W-1:0]};
               prod_d   = '0;
               cnt_d    = '0;
               exp_d    = {2'b00, a_q[W-2:MAN_W]} + {2'b00, b_q[W-2:MAN_W]} - BIAS;
               state_d  = ST_MUL;
            end
         end
         ST_MUL: begin
            prod_d   = prod_q + partial;
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            cnt_d    = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) state_d = ST_NORM;
         end
         ST_NORM: begin
            // Product lies in [1,4); a set MSB means [2,4).
            if (prod_q[P_W-1]) begin
               sig_d = prod_q[P_W-1:SIG_W];
               grs_d = {prod_q[SIG_W-1], prod_q[SIG_W-2], |prod_q[SIG_W-3:0]};
               exp_d = exp_q + EXP_ONE;
            end else begin
               sig_d = prod_q[P_W-2:SIG_W-1];
               grs_d = {prod_q[SIG_W-2], prod_q[SIG_W-3], |prod_q[SIG_W-4:0]};
            end
            state_d = ST_ROUND;
         end
         ST_ROUND: begin
            result_d    = rp_result;
            fflags_d    = rp_flags;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         rm_q        <= '0;
         spec_q      <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
         exp_q       <= '0;
         sign_q      <= 1'b0;
         sig_q       <= '0;
         grs_q       <= '0;
         result_q    <= '0;
         fflags_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rm_q        <= rm_d;
         spec_q      <= spec_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         prod_q      <= prod_d;
         cnt_q       <= cnt_d;
         exp_q       <= exp_d;
         sign_q      <= sign_d;
         sig_q       <= sig_d;
         grs_q       <= grs_d;
         result_q    <= result_d;
         fflags_q    <= fflags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign fflags    = fflags_q;

endmodule
